// File: rtl/tail_light_monitor.sv
// tail_light_monitor
//   Watches the 3-bit tail-light pattern and tracks whether it follows the
//   S0->S1->S2->S3->S0 sequence (001, 011, 111, 000). After LOCK_LEN
//   consecutive correct transitions the monitor locks. While locked it counts
//   completed S3->S0 wraps. It also counts every loss of lock, whether caused
//   by an out-of-sequence code or by an illegal code.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   light[2:0]   tail-light pattern
//   light_valid  light is sampled only when high
//   state_code   decoded state of the last legal sample (0..3)
//   locked       monitor is synchronized to the sequence
//   seq_err      one-cycle pulse: a legal code broke the sequence while locked
//   illegal      one-cycle pulse: the sampled code is not a legal pattern
//   cycle_count  S3->S0 wraps taken while already locked (saturating)
//   err_count    lock losses (saturating)
module tail_light_monitor #(
  parameter int LOCK_LEN = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       light,
  input  logic             light_valid,
  output logic [1:0]       state_code,
  output logic             locked,
  output logic             seq_err,
  output logic             illegal,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} fsm_e;

  fsm_e             fsm_q, fsm_d;
  logic [1:0]       state_code_q, state_code_d;
  logic [1:0]       prev_code_q, prev_code_d;
  logic             prev_ok_q, prev_ok_d;
  logic [2:0]       match_cnt_q, match_cnt_d;
  logic             seq_err_q, seq_err_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  logic       legal;
  logic [1:0] code;
  logic       is_succ;
  logic [2:0] match_inc;
  logic       err_inc;

  // Pattern decode
  always_comb begin
    legal = 1'b1;
    code  = 2'd0;
    case (light)
      3'b001:  code = 2'd0;
      3'b011:  code = 2'd1;
      3'b111:  code = 2'd2;
      3'b000:  code = 2'd3;
      default: legal = 1'b0;
    endcase
  end

  // A successor comparison is meaningful only when the previous sample was legal
  assign is_succ   = prev_ok_q && (code == prev_code_q + 2'd1);
  assign match_inc = match_cnt_q + 3'd1;

  always_comb begin
    fsm_d         = fsm_q;
    state_code_d  = state_code_q;
    prev_code_d   = prev_code_q;
    prev_ok_d     = prev_ok_q;
    match_cnt_d   = match_cnt_q;
    seq_err_d     = 1'b0;
    illegal_d     = 1'b0;
    cycle_count_d = cycle_count_q;
    err_inc       = 1'b0;

    if (light_valid) begin
      if (!legal) begin
        illegal_d   = 1'b1;
        prev_ok_d   = 1'b0;
        match_cnt_d = 3'd0;
        if (fsm_q == LOCKED) begin
          fsm_d   = UNLOCKED;
          err_inc = 1'b1;
        end
      end else begin
        state_code_d = code;
        prev_code_d  = code;
        prev_ok_d    = 1'b1;
        case (fsm_q)
          UNLOCKED: begin
            if (is_succ) begin
              if (match_inc == 3'(LOCK_LEN)) begin
                fsm_d       = LOCKED;
                match_cnt_d = 3'd0;
              end else begin
                match_cnt_d = match_inc;
              end
            end else begin
              match_cnt_d = 3'd0;
            end
          end
          LOCKED: begin
            if (is_succ) begin
              // Wraps count only while already locked, never on the locking edge
              if (prev_code_q == 2'd3 && cycle_count_q != {CNT_W{1'b1}})
                cycle_count_d = cycle_count_q + CNT_W'(1);
            end else begin
              seq_err_d   = 1'b1;
              fsm_d       = UNLOCKED;
              match_cnt_d = 3'd0;
              err_inc     = 1'b1;
            end
          end
          default: fsm_d = UNLOCKED;
        endcase
      end
    end

    err_count_d = err_count_q;
    if (err_inc && err_count_q != {CNT_W{1'b1}})
      err_count_d = err_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q         <= UNLOCKED;
      state_code_q  <= 2'd0;
      prev_code_q   <= 2'd0;
      prev_ok_q     <= 1'b0;
      match_cnt_q   <= 3'd0;
      seq_err_q     <= 1'b0;
      illegal_q     <= 1'b0;
      cycle_count_q <= '0;
      err_count_q   <= '0;
    end else begin
      fsm_q         <= fsm_d;
      state_code_q  <= state_code_d;
      prev_code_q   <= prev_code_d;
      prev_ok_q     <= prev_ok_d;
      match_cnt_q   <= match_cnt_d;
      seq_err_q     <= seq_err_d;
      illegal_q     <= illegal_d;
      cycle_count_q <= cycle_count_d;
      err_count_q   <= err_count_d;
    end
  end

  assign state_code  = state_code_q;
  assign locked      = (fsm_q == LOCKED);
  assign seq_err     = seq_err_q;
  assign illegal     = illegal_q;
  assign cycle_count = cycle_count_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_tail_light_monitor.sv
// Bench for tail_light_monitor: two instances share the stimulus, one with
// default widths and one with CNT_W=2 for saturation. A run-length model is
// compared against both every cycle, and hand-computed literals pin key points.
module tb_tail_light_monitor;
  localparam int LL = 2;

  logic       clk;
  logic       reset;
  logic [2:0] light;
  logic       light_valid;

  logic [1:0] a_sc, b_sc;
  logic       a_lk, b_lk, a_se, b_se, a_il, b_il;
  logic [7:0] a_cc, a_ec;
  logic [1:0] b_cc, b_ec;

  tail_light_monitor #(.LOCK_LEN(LL), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .light(light), .light_valid(light_valid),
    .state_code(a_sc), .locked(a_lk), .seq_err(a_se), .illegal(a_il),
    .cycle_count(a_cc), .err_count(a_ec));

  tail_light_monitor #(.LOCK_LEN(LL), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .light(light), .light_valid(light_valid),
    .state_code(b_sc), .locked(b_lk), .seq_err(b_se), .illegal(b_il),
    .cycle_count(b_cc), .err_count(b_ec));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model state: the number of consecutive successor transitions since the
  // last break. The monitor is locked once this run length reaches LL. Counts
  // are kept unbounded and clipped only when compared.
  int m_run, m_prev, m_sc, m_cc, m_ec;
  bit m_have, m_lk, m_se, m_il;

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic int decode(input logic [2:0] l);
    case (l)
      3'b001:  return 0;
      3'b011:  return 1;
      3'b111:  return 2;
      3'b000:  return 3;
      default: return -1;
    endcase
  endfunction

  always @(posedge clk) begin
    int c;
    bit succ;
    if (reset) begin
      m_run = 0; m_prev = 0; m_sc = 0; m_cc = 0; m_ec = 0;
      m_have = 0; m_lk = 0; m_se = 0; m_il = 0;
    end else begin
      m_se = 0; m_il = 0;
      if (light_valid) begin
        c = decode(light);
        if (c < 0) begin
          m_il = 1;
          if (m_lk) m_ec++;
          m_lk = 0; m_have = 0; m_run = 0;
        end else begin
          succ = m_have && (c == (m_prev + 1) % 4);
          if (m_lk) begin
            if (succ) begin
              if (m_prev == 3) m_cc++;
            end else begin
              m_se = 1; m_ec++; m_lk = 0; m_run = 0;
            end
          end else if (succ) begin
            m_run++;
            if (m_run >= LL) m_lk = 1;
          end else begin
            m_run = 0;
          end
          m_prev = c; m_sc = c; m_have = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("a.state_code", 32'(a_sc), 32'(m_sc));
    chk("a.locked", 32'(a_lk), 32'(m_lk));
    chk("a.seq_err", 32'(a_se), 32'(m_se));
    chk("a.illegal", 32'(a_il), 32'(m_il));
    chk("a.cycle_count", 32'(a_cc), 32'(sat(m_cc, 8)));
    chk("a.err_count", 32'(a_ec), 32'(sat(m_ec, 8)));
    chk("b.state_code", 32'(b_sc), 32'(m_sc));
    chk("b.locked", 32'(b_lk), 32'(m_lk));
    chk("b.cycle_count", 32'(b_cc), 32'(sat(m_cc, 2)));
    chk("b.err_count", 32'(b_ec), 32'(sat(m_ec, 2)));
  end

  // Drive inputs right after a falling edge; return on the next falling edge,
  // by which point the outputs show this sample.
  task automatic step(input logic r, input logic v, input logic [2:0] l);
    reset = r; light_valid = v; light = l;
    @(negedge clk);
  endtask

  task automatic sv(input logic [2:0] l);
    step(1'b0, 1'b1, l);
  endtask

  initial begin
    // Reset takes priority over a valid sample
    step(1'b1, 1'b0, 3'b000);
    step(1'b1, 1'b1, 3'b011);
    chk("rst.state_code", 32'(a_sc), 0);
    chk("rst.locked", 32'(a_lk), 0);
    chk("rst.cycle_count", 32'(a_cc), 0);
    chk("rst.err_count", 32'(a_ec), 0);

    // Lock after two correct transitions
    sv(3'b001); sv(3'b011);
    chk("lock.early", 32'(a_lk), 0);
    sv(3'b111);
    chk("lock.locked", 32'(a_lk), 1);
    chk("lock.state_code", 32'(a_sc), 2);
    chk("lock.pulses", 32'({a_se, a_il}), 0);

    // Wrap while locked
    sv(3'b000); sv(3'b001);
    chk("wrap.cycle_count", 32'(a_cc), 1);
    chk("wrap.locked", 32'(a_lk), 1);
    chk("wrap.err_count", 32'(a_ec), 0);
    sv(3'b011);

    // Locked at S1, S3 arrives instead of S2
    sv(3'b000);
    chk("seqerr.pulse", 32'(a_se), 1);
    chk("seqerr.locked", 32'(a_lk), 0);
    chk("seqerr.err_count", 32'(a_ec), 1);
    chk("seqerr.state_code", 32'(a_sc), 3);
    step(1'b0, 1'b0, 3'b010);
    chk("seqerr.one_cycle", 32'(a_se), 0);

    // Relock from the S3 base, then feed an illegal code
    sv(3'b001); sv(3'b011); sv(3'b111);
    chk("relock.locked", 32'(a_lk), 1);
    sv(3'b101);
    chk("illegal.pulse", 32'(a_il), 1);
    chk("illegal.seq_err", 32'(a_se), 0);
    chk("illegal.locked", 32'(a_lk), 0);
    chk("illegal.err_count", 32'(a_ec), 2);
    chk("illegal.state_code", 32'(a_sc), 2);

    // The S3->S0 transition that locks the monitor is not counted as a wrap
    sv(3'b111); sv(3'b000); sv(3'b001);
    chk("lockwrap.locked", 32'(a_lk), 1);
    chk("lockwrap.cycle_count", 32'(a_cc), 1);

    // Idle cycles while locked at S2 change nothing
    sv(3'b011); sv(3'b111);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'b010);
    sv(3'b000);
    chk("idle.locked", 32'(a_lk), 1);
    chk("idle.state_code", 32'(a_sc), 3);
    chk("idle.pulses", 32'({a_se, a_il}), 0);
    chk("idle.cycle_count", 32'(a_cc), 1);

    // Wraps: one here plus five full cycles. CNT_W=2 saturates at 3
    sv(3'b001);
    for (int i = 0; i < 5; i++) begin
      sv(3'b011); sv(3'b111); sv(3'b000); sv(3'b001);
    end
    chk("sat.a_cycle_count", 32'(a_cc), 7);
    chk("sat.b_cycle_count", 32'(b_cc), 3);

    // A repeated code breaks the sequence, then relock and go illegal: err saturates
    sv(3'b001);
    chk("repeat.seq_err", 32'(a_se), 1);
    sv(3'b011); sv(3'b111); sv(3'b101);
    chk("sat.a_err_count", 32'(a_ec), 4);
    chk("sat.b_err_count", 32'(b_ec), 3);

    // Relock, then reset mid-stream
    sv(3'b001); sv(3'b011); sv(3'b111);
    chk("prerst.locked", 32'(b_lk), 1);
    step(1'b1, 1'b1, 3'b000);
    chk("midrst.b_outputs", 32'({b_sc, b_lk, b_se, b_il, b_cc, b_ec}), 0);
    chk("midrst.a_outputs", 32'({a_sc, a_lk, a_se, a_il, a_cc, a_ec}), 0);

    // After reset, history is gone: lock needs two fresh transitions
    sv(3'b011); sv(3'b111);
    chk("fresh.not_yet", 32'(a_lk), 0);
    sv(3'b000);
    chk("fresh.locked", 32'(a_lk), 1);

    step(1'b0, 1'b0, 3'b000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
